// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared state encoding, memory map constants and IorD select codes for the multicycle MIPS memory path.
package mips_mem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
  localparam logic [31:0] DATA_SPLIT_BASE = 32'h1000_0000;
  localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
  localparam logic SEL_PC = 1'b0;
  localparam logic SEL_ALU = 1'b1;
endpackage

// File: rtl/mem_access_unit_wait_counter.sv
// wait_counter: loadable down-counter with zero flag that holds at zero; shared by multicycle stalls.
module wait_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);
  assign zero = count == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (load) count <= load_val;
    else if (dec && !zero) count <= count - 1'b1;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: handshaked fetch/load/store sequencer in front of the unified memory, capturing into IR or MDR.
// Optional MEM_WRITE_PROTECT_EN faults stores addressed below DATA_SPLIT instead of issuing them.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               WAIT_CYCLES = 1,
  parameter logic [WIDTH-1:0] DATA_SPLIT  = WIDTH'(DATA_SPLIT_BASE)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_i,
  input  logic             we_i,
  input  logic             i_or_d_i,
  input  logic             ir_load_i,
  input  logic [WIDTH-1:0] pc_i,
  input  logic [WIDTH-1:0] alu_out_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [WIDTH-1:0] mem_rdata_i,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  output logic             mem_we_o,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] mdr_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             fault_o
);
`ifdef MEM_WRITE_PROTECT_EN
  localparam logic PROTECT = 1'b1;
`else
  localparam logic PROTECT = 1'b0;
`endif
  state_t           state, next_state;
  logic [WIDTH-1:0] addr_q, wdata_q, instr_q, mdr_q, sel_addr;
  logic             we_q, ir_load_q, bad_q, bad_d, accept, last, cnt_zero;
  logic [3:0]       cnt;
  assign sel_addr = i_or_d_i == SEL_ALU ? alu_out_i : pc_i;
  // A faulting access still walks through ACCESS so its timing matches a good one.
  assign bad_d = |sel_addr[1:0] || (PROTECT && we_i && sel_addr < DATA_SPLIT);
  assign accept = state == IDLE && req_i;
  assign last = state == ACCESS && cnt_zero;
  always_comb begin
    next_state = state == IDLE   ? (req_i ? ACCESS : IDLE) :
                 state == ACCESS ? (cnt_zero ? DONE : ACCESS) : IDLE;
  end
  assign busy_o = state == ACCESS;
  assign done_o = state == DONE;
  assign fault_o = done_o && bad_q;
  assign mem_we_o = last && we_q && !bad_q;
  assign mem_addr_o = addr_q;
  assign mem_wdata_o = wdata_q;
  assign instr_o = instr_q;
  assign mdr_o = mdr_q;
  wait_counter #(.W(4)) u_wait (
    .clk      (clock),
    .rst      (reset),
    .load     (accept),
    .load_val (4'(WAIT_CYCLES - 1)),
    .dec      (busy_o),
    .count    (cnt),
    .zero     (cnt_zero)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      ir_load_q <= 1'b0;
      bad_q <= 1'b0;
      instr_q <= '0;
      mdr_q <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        addr_q <= sel_addr;
        wdata_q <= wdata_i;
        we_q <= we_i;
        ir_load_q <= ir_load_i;
        bad_q <= bad_d;
      end
      if (last && !we_q && !bad_q) begin
        if (ir_load_q) instr_q <= mem_rdata_i;
        else mdr_q <= mem_rdata_i;
      end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven scoreboard bench over two instances (WAIT_CYCLES=1 and 3) plus reset and held-request sequences.
module tb_mem_access_unit;
  typedef struct {
    int          d;
    logic        we, iord, irl;
    logic [31:0] pc, alu, wdata, rdata;
  } vec_t;
  typedef struct {
    logic [31:0] instr, mdr, addr, wdata;
    logic        fault;
    int          wes, busy;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] req, mwe, busy, done, fault;
  logic we, iord, irl;
  logic [31:0] pc, alu, wdata, rdata;
  logic [1:0][31:0] addr_o, wdata_o, instr_o, mdr_o;
  logic [31:0] m_ir[2], m_mdr[2];
  exp_t sb[$];
  vec_t tbl[8];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  mem_access_unit #(.WIDTH(32), .WAIT_CYCLES(1)) u1 (
    .clock(clk), .reset(rst), .req_i(req[0]), .we_i(we), .i_or_d_i(iord), .ir_load_i(irl),
    .pc_i(pc), .alu_out_i(alu), .wdata_i(wdata), .mem_rdata_i(rdata),
    .mem_addr_o(addr_o[0]), .mem_wdata_o(wdata_o[0]), .mem_we_o(mwe[0]),
    .instr_o(instr_o[0]), .mdr_o(mdr_o[0]), .busy_o(busy[0]), .done_o(done[0]), .fault_o(fault[0])
  );
  mem_access_unit #(.WIDTH(32), .WAIT_CYCLES(3)) u3 (
    .clock(clk), .reset(rst), .req_i(req[1]), .we_i(we), .i_or_d_i(iord), .ir_load_i(irl),
    .pc_i(pc), .alu_out_i(alu), .wdata_i(wdata), .mem_rdata_i(rdata),
    .mem_addr_o(addr_o[1]), .mem_wdata_o(wdata_o[1]), .mem_we_o(mwe[1]),
    .instr_o(instr_o[1]), .mdr_o(mdr_o[1]), .busy_o(busy[1]), .done_o(done[1]), .fault_o(fault[1])
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, want);
    end
  endtask
  task automatic chk_idle_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_addr%0d", tag, d), addr_o[d], 32'h0);
      chk($sformatf("%s_wdata%0d", tag, d), wdata_o[d], 32'h0);
      chk($sformatf("%s_instr%0d", tag, d), instr_o[d], 32'h0);
      chk($sformatf("%s_mdr%0d", tag, d), mdr_o[d], 32'h0);
      chk($sformatf("%s_we%0d", tag, d), 32'(mwe[d]), 32'h0);
      chk($sformatf("%s_busy%0d", tag, d), 32'(busy[d]), 32'h0);
      chk($sformatf("%s_done%0d", tag, d), 32'(done[d]), 32'h0);
      chk($sformatf("%s_fault%0d", tag, d), 32'(fault[d]), 32'h0);
    end
  endtask
  task automatic run(input int idx, input vec_t v);
    exp_t e, got;
    logic [31:0] a, a_seen;
    logic isbad, moved;
    int d, nb, nw, n;
    d = v.d;
    a = v.iord ? v.alu : v.pc;
    isbad = a[1:0] != 2'b00;
`ifdef MEM_WRITE_PROTECT_EN
    if (v.we && a < 32'h1000_0000) isbad = 1'b1;
`endif
    if (!v.we && !isbad) begin
      if (v.irl) m_ir[d] = v.rdata;
      else m_mdr[d] = v.rdata;
    end
    e.instr = m_ir[d];
    e.mdr = m_mdr[d];
    e.addr = a;
    e.wdata = v.wdata;
    e.fault = isbad;
    e.wes = (v.we && !isbad) ? 1 : 0;
    e.busy = d == 1 ? 3 : 1;
    @(negedge clk);
    we = v.we; iord = v.iord; irl = v.irl; pc = v.pc; alu = v.alu; wdata = v.wdata; rdata = v.rdata;
    req[d] = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    req[d] = 1'b0;
    nb = 0; nw = 0; n = 0; moved = 1'b0; a_seen = addr_o[d];
    while (!done[d] && n < 20) begin
      if (busy[d]) nb++;
      if (mwe[d]) nw++;
      if (addr_o[d] !== a_seen) moved = 1'b1;
      n++;
      @(negedge clk);
    end
    got = sb.pop_front();
    chk($sformatf("v%0d_done", idx), 32'(done[d]), 32'h1);
    chk($sformatf("v%0d_busy_cycles", idx), 32'(nb), 32'(got.busy));
    chk($sformatf("v%0d_we_pulses", idx), 32'(nw), 32'(got.wes));
    chk($sformatf("v%0d_addr", idx), a_seen, got.addr);
    chk($sformatf("v%0d_addr_stable", idx), 32'(moved), 32'h0);
    chk($sformatf("v%0d_wdata", idx), wdata_o[d], got.wdata);
    chk($sformatf("v%0d_fault", idx), 32'(fault[d]), 32'(got.fault));
    chk($sformatf("v%0d_instr", idx), instr_o[d], got.instr);
    chk($sformatf("v%0d_mdr", idx), mdr_o[d], got.mdr);
    @(negedge clk);
    chk($sformatf("v%0d_done_pulse", idx), 32'(done[d]), 32'h0);
  endtask
  initial begin
    int nd, first, second, nwe;
    tbl[0] = '{0, 1'b0, 1'b0, 1'b1, 32'h0040_0004, 32'h0, 32'h0, 32'h2008_000A};
    tbl[1] = '{0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h1001_0000, 32'hDEAD_BEEF, 32'h0};
    tbl[2] = '{1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h1001_0008, 32'h0, 32'h1234_5678};
    tbl[3] = '{0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h1001_0002, 32'h1111_1111, 32'h0};
    tbl[4] = '{1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h1001_0001, 32'h0, 32'hFFFF_FFFF};
    tbl[5] = '{1, 1'b0, 1'b0, 1'b1, 32'h0040_0008, 32'h0, 32'h0, 32'h8C09_0004};
    tbl[6] = '{1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0040_0000, 32'h0BAD_C0DE, 32'h0};
    tbl[7] = '{0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h1001_0004, 32'h0, 32'h0BAD_F00D};
    rst = 1'b1; req = 2'b00; we = 1'b0; iord = 1'b0; irl = 1'b0;
    pc = '0; alu = '0; wdata = '0; rdata = '0;
    for (int d = 0; d < 2; d++) begin m_ir[d] = '0; m_mdr[d] = '0; end
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;
    for (int i = 0; i < 8; i++) run(i, tbl[i]);
    // Reset lands in the 2nd ACCESS cycle of a 3-cycle store.
    @(negedge clk);
    we = 1'b1; iord = 1'b1; alu = 32'h1001_0010; wdata = 32'hCAFE_F00D; req[1] = 1'b1;
    @(negedge clk);
    req[1] = 1'b0;
    chk("midrst_busy_c1", 32'(busy[1]), 32'h1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk_idle_outputs("midrst");
    for (int d = 0; d < 2; d++) begin m_ir[d] = '0; m_mdr[d] = '0; end
    @(negedge clk);
    rst = 1'b0;
    nwe = 0; nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (mwe[1]) nwe++;
      if (done[1]) nd++;
    end
    chk("midrst_no_write", 32'(nwe), 32'h0);
    chk("midrst_no_done", 32'(nd), 32'h0);
    run(8, tbl[2]);
    // req_i held high: one acceptance every WAIT_CYCLES+2 cycles.
    @(negedge clk);
    we = 1'b0; iord = 1'b1; irl = 1'b0; alu = 32'h1001_0020; rdata = 32'h55AA_55AA; req[0] = 1'b1;
    m_mdr[0] = 32'h55AA_55AA;
    nd = 0; first = -1; second = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done[0]) begin
        nd++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    req[0] = 1'b0;
    chk("held_done_count", 32'(nd), 32'd4);
    chk("held_first_done", 32'(first), 32'd2);
    chk("held_spacing", 32'(second - first), 32'd3);
    chk("held_mdr", mdr_o[0], m_mdr[0]);
    chk("held_instr", instr_o[0], m_ir[0]);
    repeat (3) @(negedge clk);
    chk("held_idle_busy", 32'(busy[0]), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
